// File: rtl/bram.sv
// Dual-ported block RAM with a registered read, modelled on the iCE40 4kb primitive.
// The read port returns 0 when not enabled and returns the incoming word on a same-address write.
module bram #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8,
    parameter int MEM_MAX = 1 << ADDR_SZ
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [ADDR_SZ-1:0] i_waddr,
    input  logic [DATA_SZ-1:0] i_wdata,
    input  logic               i_rd_en,
    input  logic [ADDR_SZ-1:0] i_raddr,
    output logic [DATA_SZ-1:0] o_rdata
);

    logic [DATA_SZ-1:0] mem [0:MEM_MAX-1];
    logic [DATA_SZ-1:0] rdata_reg;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            rdata_reg <= (i_wr_en && (i_waddr == i_raddr)) ? i_wdata : mem[i_raddr];
        end else begin
            rdata_reg <= '0;
        end
    end

    assign o_rdata = rdata_reg;

endmodule

// File: rtl/bram_fifo.sv
// Synchronous FIFO controller around bram: wrap-bit pointers, occupancy count,
// one-cycle read latency and sticky overflow/underflow flags.
module bram_fifo #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [DATA_SZ-1:0] i_wdata,
    output logic               o_full,
    input  logic               i_rd,
    output logic [DATA_SZ-1:0] o_rdata,
    output logic               o_valid,
    output logic               o_empty,
    output logic [ADDR_SZ:0]   o_count,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int DEPTH = 1 << ADDR_SZ;
    localparam logic [ADDR_SZ:0] PTR_ONE = 1;

    logic [ADDR_SZ:0] wr_ptr_reg;
    logic [ADDR_SZ:0] rd_ptr_reg;
    logic             valid_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic full;
    logic empty;
    logic push_accept;
    logic pop_accept;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_SZ-1:0] == rd_ptr_reg[ADDR_SZ-1:0]) &&
                   (wr_ptr_reg[ADDR_SZ] != rd_ptr_reg[ADDR_SZ]);

    // Full blocks a push even when a pop is accepted alongside it, so the two
    // bram ports never hit the same address and write-through cannot leak in.
    assign push_accept = i_wr && !full && !i_rst;
    assign pop_accept  = i_rd && !empty && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_accept) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            valid_reg <= pop_accept;
            if (i_wr && full) begin
                overflow_reg <= 1'b1;
            end
            if (i_rd && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    bram #(
        .DATA_SZ(DATA_SZ),
        .ADDR_SZ(ADDR_SZ),
        .MEM_MAX(DEPTH)
    ) u_bram (
        .i_clk   (i_clk),
        .i_wr_en (push_accept),
        .i_waddr (wr_ptr_reg[ADDR_SZ-1:0]),
        .i_wdata (i_wdata),
        .i_rd_en (pop_accept),
        .i_raddr (rd_ptr_reg[ADDR_SZ-1:0]),
        .o_rdata (o_rdata)
    );

    assign o_full      = full;
    assign o_empty     = empty;
    assign o_count     = wr_ptr_reg - rd_ptr_reg;
    assign o_valid     = valid_reg;
    assign o_overflow  = overflow_reg;
    assign o_underflow = underflow_reg;

endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: a table of directed vectors, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_bram_fifo;

    localparam int DEPTH = 256;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_wr = 1'b0;
    logic [15:0] i_wdata = '0;
    logic        i_rd = 1'b0;
    logic        o_full;
    logic [15:0] o_rdata;
    logic        o_valid;
    logic        o_empty;
    logic [8:0]  o_count;
    logic        o_overflow;
    logic        o_underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    always #5 i_clk = ~i_clk;

    bram_fifo #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr        (i_wr),
        .i_wdata     (i_wdata),
        .o_full      (o_full),
        .i_rd        (i_rd),
        .o_rdata     (o_rdata),
        .o_valid     (o_valid),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    typedef struct {
        logic        wr;
        logic [15:0] wdata;
        logic        rd;
        logic        rst;
        logic        ev;
        logic [15:0] erdata;
        int          ecount;
        logic        eempty;
        logic        efull;
        logic        eovf;
        logic        eunf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One transaction: drive inputs, let one edge pass, sample 1 time unit later.
    task automatic drive(input logic wr, input logic [15:0] wd, input logic rd, input logic rst);
        i_wr = wr;
        i_wdata = wd;
        i_rd = rd;
        i_rst = rst;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
        i_rd = 1'b0;
        i_rst = 1'b0;
        $display("t=%0t wr=%b wdata=%h rd=%b rst=%b -> valid=%b rdata=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                 $time, wr, wd, rd, rst, o_valid, o_rdata, o_count, o_empty, o_full, o_overflow, o_underflow);
    endtask

    // Reference model: a plain queue of stored words plus sticky flags.
    task automatic model_cycle(input logic wr, input logic [15:0] wd, input logic rd, input logic rst);
        logic        ev;
        logic [15:0] ed;
        bit          was_full;
        bit          was_empty;
        ev = 1'b0;
        ed = '0;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rd && !was_empty) begin
                ev = 1'b1;
                ed = q.pop_front();
            end
            if (wr && !was_full) q.push_back(wd);
            if (wr && was_full) m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
        end
        drive(wr, wd, rd, rst);
        chk("m_valid", 32'(o_valid), 32'(ev));
        chk("m_rdata", 32'(o_rdata), 32'(ed));
        chk("m_count", 32'(o_count), 32'(q.size()));
        chk("m_empty", 32'(o_empty), 32'(q.size() == 0));
        chk("m_full", 32'(o_full), 32'(q.size() == DEPTH));
        chk("m_ovf", 32'(o_overflow), 32'(m_ovf));
        chk("m_unf", 32'(o_underflow), 32'(m_unf));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3333, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'h00BB, 1'b1, 1'b0, 1'b1, 16'h00AA, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00BB, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        @(posedge i_clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].rst);
            chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_rdata", i), 32'(o_rdata), 32'(vecs[i].erdata));
            chk($sformatf("v%0d_count", i), 32'(o_count), 32'(vecs[i].ecount));
            chk($sformatf("v%0d_empty", i), 32'(o_empty), 32'(vecs[i].eempty));
            chk($sformatf("v%0d_full", i), 32'(o_full), 32'(vecs[i].efull));
            chk($sformatf("v%0d_ovf", i), 32'(o_overflow), 32'(vecs[i].eovf));
            chk($sformatf("v%0d_unf", i), 32'(o_underflow), 32'(vecs[i].eunf));
        end

        // Fill to DEPTH, then push+pop while full: pop wins, push rejected.
        model_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) model_cycle(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_count", 32'(o_count), 32'd256);
        model_cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        chk("ovf_rdata", 32'(o_rdata), 32'h0000);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd255);
        for (int i = 0; i < DEPTH - 1; i++) model_cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Pop from empty.
        model_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        model_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("unf_flag", 32'(o_underflow), 32'd1);
        chk("unf_valid", 32'(o_valid), 32'd0);
        chk("unf_count", 32'(o_count), 32'd0);

        // Steady push+pop at depth 10 across the address wrap.
        model_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) model_cycle(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            model_cycle(1'b1, 16'(i + 10), 1'b1, 1'b0);
            chk("steady_count", 32'(o_count), 32'd10);
        end
        chk("steady_ovf", 32'(o_overflow), 32'd0);
        chk("steady_unf", 32'(o_underflow), 32'd0);

        // Reset mid-operation with a pop in flight and a sticky flag set.
        model_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        model_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) model_cycle(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
        model_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        i_rst = 1'b1;
        #1;
        chk("rstcyc_valid", 32'(o_valid), 32'd1);
        chk("rstcyc_rdata", 32'(o_rdata), 32'h0050);
        model_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_unf", 32'(o_underflow), 32'd0);
        model_cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
        model_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_rdata", 32'(o_rdata), 32'hABCD);
        model_cycle(1'b0, 16'h0, 1'b0, 1'b0);

        // Randomized traffic with phases biased toward filling, draining and mixing.
        for (int i = 0; i < 3000; i++) begin
            int ph;
            logic wr;
            logic rd;
            logic rst;
            ph  = (i / 400) % 3;
            wr  = (ph == 0) ? ($urandom_range(0, 9) < 9) : (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
            rd  = (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 999) == 0);
            model_cycle(wr, 16'($urandom), rd, rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Synchronous FIFO controller that drives both ports of the iCE40 4kb dual-ported `bram`: write port for pushes, read port for pops.
- Supplies the address sequencing, full/empty tracking and occupancy count that `bram` lacks, so producers and consumers see a simple push/pop interface.
- Used for buffering between serial/UART and processing blocks on Fomu.

Parameters:
DATA_SZ  16  bits per FIFO word; passed to `bram`
ADDR_SZ  8  bits per `bram` address; FIFO depth DEPTH = 1<<ADDR_SZ (256 entries)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_wr  input  1  push request
i_wdata  input  DATA_SZ  data to push
o_full  output  1  FIFO holds DEPTH words
i_rd  input  1  pop request
o_rdata  output  DATA_SZ  popped data, meaningful only while o_valid=1
o_valid  output  1  o_rdata holds data from the pop accepted in the previous cycle
o_empty  output  1  FIFO holds 0 words
o_count  output  ADDR_SZ+1  current occupancy, 0..DEPTH
o_overflow  output  1  sticky: a push was attempted while full
o_underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Interface: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Pointers: wr_ptr and rd_ptr are ADDR_SZ+1 bits each. The low ADDR_SZ bits address `bram`; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) && (MSB differs).
- Count: o_count = wr_ptr - rd_ptr, modulo 2^(ADDR_SZ+1).
  - Registered, or derived combinationally from the registered pointers; either way it must be valid in the same cycle as the pointers.
- Push acceptance: accept = i_wr && !full && !i_rst.
  - Drives bram i_wr_en=accept, i_waddr=wr_ptr[ADDR_SZ-1:0], i_wdata=i_wdata.
  - wr_ptr increments next cycle.
- Pop acceptance: accept = i_rd && !empty && !i_rst.
  - Drives bram i_rd_en=accept, i_raddr=rd_ptr[ADDR_SZ-1:0].
  - rd_ptr increments next cycle.
- Read latency: exactly 1 cycle.
  - o_valid is a register set to the pop accept of the previous cycle.
  - o_rdata is wired to bram o_rdata. It reads 0 whenever o_valid=0, because `bram` outputs 0 when not read-enabled.
- Push while full: rejected, even if a pop is accepted in the same cycle.
  - This keeps waddr != raddr on every cycle where both ports are enabled.
  - Reason: `bram` is write-thru; a same-address push/pop would return the new word instead of the oldest.
- Pop while empty: rejected, even if a push is accepted in the same cycle. No bypass; the pushed word becomes poppable next cycle.
- Simultaneous accepted push and pop: both pointers advance and o_count is unchanged.
- Wrap-around: pointers wrap naturally at 2^(ADDR_SZ+1). Addresses wrap from DEPTH-1 to 0 with no bubble.
- Errors:
  - o_overflow sets on i_wr && full.
  - o_underflow sets on i_rd && empty.
  - Both stay set until reset.
- Reset values (next cycle after i_rst=1): wr_ptr=0, rd_ptr=0, o_empty=1, o_full=0, o_count=0, o_valid=0, o_overflow=0, o_underflow=0.
- Reset mid-operation:
  - A pop accepted in the cycle before reset still yields o_valid=1 during the reset cycle. o_valid=0 from the cycle after reset onward.
  - No `bram` write occurs while i_rst=1.
  - `bram` contents are not cleared; they are unreachable through the reset pointers.

Decomposition:
- No shared package is needed.
- localparam DEPTH = 1<<ADDR_SZ lives in the module.
- One sub-module: the existing `bram`, instantiated with DATA_SZ, ADDR_SZ, and MEM_MAX=DEPTH.
- All control logic (pointers, flags, count, valid, sticky errors) lives in bram_fifo itself.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop 3 times.
  - Expect o_valid high for 3 cycles, one cycle after each pop, with o_rdata 0x1111, 0x2222, 0x3333.
  - Expect o_count sequence 1,2,3,2,1,0 and o_empty=1 at the end.
- Push 256 words (value = index).
  - Expect o_full=1 and o_count=256.
  - A 257th push with simultaneous pop: pop returns 0x0000, push is rejected, o_overflow=1, o_count=255.
- From empty, assert i_rd.
  - Expect no bram read, o_valid=0 next cycle, o_underflow=1, o_count stays 0.
- Fill with 10 words, then assert i_wr and i_rd together for 300 cycles with an incrementing data pattern.
  - Expect o_count constant at 10, in-order data across the address wrap, and no flag errors.
- Push 5 words, pop once, then assert i_rst for 1 cycle.
  - Expect o_valid=1 with word 0 during the reset cycle, then o_valid=0, o_count=0, o_empty=1, and sticky flags cleared.
  - A subsequent push of 0xABCD then pop returns 0xABCD.
- With 1 word (0x00AA) stored, push 0x00BB and pop in the same cycle.
  - Expect pop returns 0x00AA, o_count stays 1, and the next pop returns 0x00BB.
